// File: rtl/spi_master.sv
// SPI master: one frame per start, per-frame mode/divider/slave select, optional ss hold for bursts.
// Define SPI_MASTER_LSB_FIRST_EN to add the lsb_first port for selectable bit order.
module spi_master #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_CS = 2,
    parameter int unsigned DIV_W  = 8,
    localparam int unsigned CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic [DIV_W-1:0]  div,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              hold,
`ifdef SPI_MASTER_LSB_FIRST_EN
    input  logic              lsb_first,
`endif
    input  logic              miso,
    output logic              sclk,
    output logic              mosi,
    output logic [NUM_CS-1:0] ss,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done
);

    localparam int unsigned TOG_W = $clog2(2 * DATA_W + 1);

    typedef enum logic [2:0] {
        IDLE,
        HELD,
        GAP,
        SETUP,
        SHIFT,
        TAIL
    } state_t;

    state_t            state;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  cnt;
    logic [TOG_W-1:0]  tog;
    logic [TOG_W-1:0]  tog_nxt;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic [DATA_W-1:0] tx_rev;
    logic [DATA_W-1:0] rx_rev;
    logic [DATA_W-1:0] tx_load;
    logic [DATA_W-1:0] rx_out;
    logic [CS_W-1:0]   cs_q;
    logic [NUM_CS-1:0] sel_mask;
    logic [NUM_CS-1:0] cur_mask;
    logic              cpol_q;
    logic              cpha_q;
    logic              hold_q;
    logic              lsb_q;
    logic              lsb_in;
    logic              sclk_q;
    logic              cnt_end;
    logic              last_tog;
    logic              sample_bit;
    logic              drive_bit;

`ifdef SPI_MASTER_LSB_FIRST_EN
    assign lsb_in = lsb_first;
`else
    assign lsb_in = 1'b0;
`endif

    // LSB-first is handled by reversing on the way in and out; the shifter is always MSB-first.
    for (genvar g = 0; g < DATA_W; g++) begin : g_rev
        assign tx_rev[g] = tx_data[DATA_W-1-g];
        assign rx_rev[g] = rx_sr[DATA_W-1-g];
    end

    // Active-low select masks; an out-of-range index matches nothing, leaving all ss high.
    for (genvar g = 0; g < NUM_CS; g++) begin : g_mask
        assign sel_mask[g] = (cs_sel != CS_W'(g));
        assign cur_mask[g] = (cs_q != CS_W'(g));
    end

    always_comb begin
        tx_load    = lsb_in ? tx_rev : tx_data;
        rx_out     = lsb_q ? rx_rev : rx_sr;
        cnt_end    = (cnt == div_q);
        tog_nxt    = tog + TOG_W'(1);
        last_tog   = (tog_nxt == TOG_W'(2 * DATA_W));
        // tog holds toggles already made, so tog[0]=0 means the coming toggle is odd.
        sample_bit = cpha_q ? tog[0] : ~tog[0];
        drive_bit  = cpha_q ? ~tog[0] : (tog[0] & ~last_tog);
    end

    // Idle clock level follows the live cpol input so it is valid even in reset.
    assign sclk = (state == IDLE) ? cpol : sclk_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            div_q   <= '0;
            cnt     <= '0;
            tog     <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            cs_q    <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            hold_q  <= 1'b0;
            lsb_q   <= 1'b0;
            sclk_q  <= 1'b0;
            mosi    <= 1'b0;
            ss      <= '1;
            rx_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, HELD: begin
                    if (start) begin
                        div_q  <= div;
                        cs_q   <= cs_sel;
                        cpol_q <= cpol;
                        cpha_q <= cpha;
                        hold_q <= hold;
                        lsb_q  <= lsb_in;
                        sclk_q <= cpol;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        tog    <= '0;
                        tx_sr  <= tx_load;
                        if (state == HELD && cs_sel != cs_q) begin
                            state <= GAP;
                            ss    <= '1;
                        end else begin
                            state <= SETUP;
                            if (state == IDLE) begin
                                ss <= sel_mask;
                            end
                            if (!cpha) begin
                                mosi  <= tx_load[DATA_W-1];
                                tx_sr <= tx_load << 1;
                            end else begin
                                mosi <= 1'b0;
                            end
                        end
                    end
                end
                GAP: begin
                    if (cnt_end) begin
                        cnt   <= '0;
                        state <= SETUP;
                        ss    <= cur_mask;
                        if (!cpha_q) begin
                            mosi  <= tx_sr[DATA_W-1];
                            tx_sr <= tx_sr << 1;
                        end else begin
                            mosi <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + DIV_W'(1);
                    end
                end
                SETUP: begin
                    if (cnt_end) begin
                        cnt   <= '0;
                        state <= SHIFT;
                    end else begin
                        cnt <= cnt + DIV_W'(1);
                    end
                end
                SHIFT: begin
                    if (cnt_end) begin
                        cnt    <= '0;
                        sclk_q <= ~sclk_q;
                        tog    <= tog_nxt;
                        if (sample_bit) begin
                            rx_sr <= {rx_sr[DATA_W-2:0], miso};
                        end
                        if (drive_bit) begin
                            mosi  <= tx_sr[DATA_W-1];
                            tx_sr <= tx_sr << 1;
                        end
                        if (last_tog) begin
                            state <= TAIL;
                            tog   <= '0;
                        end
                    end else begin
                        cnt <= cnt + DIV_W'(1);
                    end
                end
                TAIL: begin
                    if (cnt_end) begin
                        cnt     <= '0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        rx_data <= rx_out;
                        if (hold_q) begin
                            state <= HELD;
                        end else begin
                            state <= IDLE;
                            ss    <= '1;
                            mosi  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + DIV_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter DATA_W, default 8, frame length in bits (range 4..32).
REQ-002 Parameter NUM_CS, default 2, number of slave-select outputs (range 1..8).
REQ-003 Parameter DIV_W, default 8, width of the clock-divider input.
REQ-004 Port clk  in  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-005 Port rst_n  in  1  reset; asynchronous, active-low.
REQ-006 Port start  in  1  one-cycle frame request.
REQ-007 Port tx_data  in  DATA_W  frame to transmit.
REQ-008 Port cs_sel  in  $clog2(NUM_CS) (min 1)  index of the slave to select.
REQ-009 Port div  in  DIV_W  half-period of sclk, equal to div+1 clk cycles.
REQ-010 Port cpol  in  1  sclk idle level.
REQ-011 Port cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge.
REQ-012 Port hold  in  1  1 = keep ss asserted after the frame (burst transfers).
REQ-013 Port miso  in  1  serial input.
REQ-014 Port sclk  out  1  serial clock.
REQ-015 Port mosi  out  1  serial output.
REQ-016 Port ss  out  NUM_CS  active-low slave selects.
REQ-017 Port rx_data  out  DATA_W  last received frame.
REQ-018 Port busy  out  1  frame in progress.
REQ-019 Port done  out  1  one-cycle end-of-frame pulse.

Function
REQ-020 States SHALL be IDLE, HELD, GAP, SETUP, SHIFT, TAIL.
REQ-021 In IDLE or HELD with busy=0, start=1 SHALL latch tx_data, cs_sel, div, cpol, cpha and hold, and SHALL set busy=1 on the next cycle.
REQ-022 start while busy=1 SHALL be ignored, with no change to the latched values.
REQ-023 On a start from IDLE, ss[cs_sel] SHALL go low on the next cycle and the FSM SHALL enter SETUP.
REQ-024 On a start from HELD with the same cs_sel, the FSM SHALL enter SETUP directly, with ss kept low and no gap.
REQ-025 On a start from HELD with a different cs_sel, the old ss SHALL go high, GAP SHALL last div+1 cycles, then the new ss SHALL go low and the FSM SHALL enter SETUP.
REQ-026 SETUP SHALL last div+1 cycles, with sclk=cpol; if cpha=0, the first data bit SHALL be on mosi at SETUP entry.
REQ-027 SHIFT SHALL toggle sclk every div+1 cycles, for exactly 2*DATA_W toggles.
REQ-028 miso SHALL be sampled on the odd-numbered toggles when cpha=0 and on the even-numbered toggles when cpha=1.
REQ-029 mosi SHALL change on the toggles that do not sample (cpha=0), or on the odd-numbered toggles (cpha=1).
REQ-030 Bit order SHALL be MSB first (see REQ-040).
REQ-031 After the last toggle, sclk SHALL equal cpol and TAIL SHALL last div+1 cycles.
REQ-032 At the end of TAIL, the following SHALL happen in the same cycle: done=1, rx_data updated, busy=0.
REQ-033 At the end of TAIL with hold=0, ss SHALL go high and the FSM SHALL enter IDLE.
REQ-034 At the end of TAIL with hold=1, ss SHALL stay low and the FSM SHALL enter HELD.
REQ-035 A start arriving in the same cycle as done SHALL be accepted.
REQ-036 A cs_sel value >= NUM_CS SHALL run the frame with all ss high.
REQ-037 In IDLE, sclk SHALL equal the current cpol input and mosi SHALL be 0.

Reset
REQ-038 While rst_n=0: ss all ones, sclk=cpol input, mosi=0, rx_data=0, busy=0, done=0, state IDLE.
REQ-039 Reset asserted mid-frame SHALL abort the frame immediately, with no done pulse.

Configuration
REQ-040 Macro SPI_MASTER_LSB_FIRST_EN selects the bit order.
- Defined: an input port lsb_first (1 bit) is added and latched at start; 1 = LSB shifted first on mosi and LSB received first into rx_data.
- Undefined: the port is absent and transfers are always MSB first.

Verification
REQ-041 Mode 0, div=1, tx=8'hA5, miso driven 8'h3C: mosi bits 1,0,1,0,0,1,0,1; rx_data=8'h3C; done 1 cycle; SETUP+SHIFT+TAIL = 36 clk cycles.
REQ-042 All four cpol/cpha modes, tx=8'h81: sclk idle level correct, sample edge per REQ-028, rx equal to looped-back miso=mosi.
REQ-043 hold=1 with cs_sel=0, then three back-to-back starts, last with hold=0: ss[0] low continuously across all four frames, then high.
REQ-044 HELD on cs 0, then start with cs_sel=1, div=3: ss[0] high for 4 cycles (GAP) before ss[1] goes low.
REQ-045 rst_n pulsed low during toggle 5: outputs return to reset values within the same cycle, no done pulse, and the next frame is correct.
